// File: rtl/mod_select_seq_pkg.sv
// mod_select_seq_pkg
//   Shared types and helpers for the sequential mod/compare/select datapath.
//   Holds the FSM state encoding, the default operand width and the helper
//   that sizes the iteration counter.
package mod_select_seq_pkg;

  // Default operand/result width used by the top level when not overridden.
  localparam int MODSEL_DEFAULT_WIDTH = 64;

  // FSM state encoding; the numeric values are fixed so that waveform
  // viewers and any external probes agree on what each code means.
  typedef enum logic [1:0] {
    MODSEL_IDLE = 2'd0,
    MODSEL_CALC = 2'd1,
    MODSEL_DONE = 2'd2
  } modsel_state_e;

  // Width of the iteration counter: ceil(log2(dataWidth)) bits, enough to
  // hold dataWidth-1, clamped to at least one bit so that tiny widths
  // still produce a legal vector.
  function automatic int modselCntWidth(input int dataWidth);
    int w;
    w = $clog2(dataWidth);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod_select_seq_iter_step.sv
// mod_select_seq_iter_step
//   One step of a restoring divider, purely combinational.
//   The partial remainder is shifted left by one, the next dividend bit is
//   appended, and the divisor is subtracted when it fits.  Because the
//   incoming remainder is always smaller than the divisor, the result
//   always fits back into DATAWIDTH bits, so the top bit of the trial value
//   can be dropped after the subtraction.
//   With a zero divisor the trial value always "fits", so the step simply
//   shifts the dividend bits in; the top level still overrides that case
//   explicitly so the result does not depend on this side effect.
module mod_select_seq_iter_step
  import mod_select_seq_pkg::*;
#(
  parameter int DATAWIDTH = MODSEL_DEFAULT_WIDTH
) (
  input  logic [DATAWIDTH-1:0] i_remIn,
  input  logic                 i_aBit,
  input  logic [DATAWIDTH-1:0] i_c,
  output logic [DATAWIDTH-1:0] o_remOut
);

  logic [DATAWIDTH:0] w_trial;
  logic [DATAWIDTH:0] w_divisor;
  logic               w_fits;

  assign w_trial   = {i_remIn, i_aBit};
  assign w_divisor = {1'b0, i_c};
  assign w_fits    = (w_trial >= w_divisor);

  assign o_remOut  = DATAWIDTH'(w_fits ? (w_trial - w_divisor) : w_trial);

endmodule

// File: rtl/mod_select_seq.sv
// mod_select_seq
//   Sequential mod/compare/select block with valid/ready handshakes.
//   Computes g = a % c with an iterative restoring divider (one quotient
//   bit per cycle, MSB first, always DATAWIDTH iterations), then registers
//   z = (g == zero) ? c+1 : a-1.  A zero divisor defines g = a; latency does
//   not change for it.
//   Optional feature macro: MODSEL_DIVZERO_ERR_EN adds the o_err port, which
//   flags a result produced with a zero divisor.
module mod_select_seq
  import mod_select_seq_pkg::*;
#(
  parameter int DATAWIDTH = MODSEL_DEFAULT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [DATAWIDTH-1:0] i_a,
  input  logic [DATAWIDTH-1:0] i_c,
  input  logic [DATAWIDTH-1:0] i_zero,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [DATAWIDTH-1:0] o_z
`ifdef MODSEL_DIVZERO_ERR_EN
  ,
  output logic                 o_err
`endif
);

  localparam int CW = modselCntWidth(DATAWIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATAWIDTH - 1);

  // Control state and captured job operands.
  modsel_state_e        r_state;
  logic [DATAWIDTH-1:0] r_a;
  logic [DATAWIDTH-1:0] r_c;
  logic [DATAWIDTH-1:0] r_zero;
  logic [DATAWIDTH-1:0] r_rem;
  logic [CW-1:0]        r_cnt;

  // Registered result side.
  logic [DATAWIDTH-1:0] r_z;
  logic                 r_outValid;
`ifdef MODSEL_DIVZERO_ERR_EN
  logic                 r_err;
`endif

  // Datapath wires.
  logic                 w_inReady;
  logic                 w_accept;
  logic                 w_aBit;
  logic [DATAWIDTH-1:0] w_remNext;
  logic                 w_divZero;
  logic [DATAWIDTH-1:0] w_g;
  logic [DATAWIDTH-1:0] w_cPlusOne;
  logic [DATAWIDTH-1:0] w_aMinusOne;
  logic [DATAWIDTH-1:0] w_zSel;

  // The block takes a new job when idle, or in the same cycle the current
  // result is being popped, so back-to-back streaming loses no cycle.
  assign w_inReady = (r_state == MODSEL_IDLE) ||
                     ((r_state == MODSEL_DONE) && i_out_ready);
  assign w_accept  = i_in_valid && w_inReady;

  // The counter walks from the MSB index down to zero, so it doubles as
  // the dividend bit selector and the "last iteration" detector.
  assign w_aBit = r_a[r_cnt];

  mod_select_seq_iter_step #(
    .DATAWIDTH (DATAWIDTH)
  ) u_iterStep (
    .i_remIn  (r_rem),
    .i_aBit   (w_aBit),
    .i_c      (r_c),
    .o_remOut (w_remNext)
  );

  // A zero divisor defines the remainder as the dividend itself; the
  // remainder from the final step is used only for a non-zero divisor.
  assign w_divZero   = (r_c == '0);
  assign w_g         = w_divZero ? r_a : w_remNext;

  // Both arms wrap modulo 2^DATAWIDTH; the compare uses the captured
  // zero value, never the live port.
  assign w_cPlusOne  = r_c + 1'b1;
  assign w_aMinusOne = r_a - 1'b1;
  assign w_zSel      = (w_g == r_zero) ? w_cPlusOne : w_aMinusOne;

  // Single FSM block: captures operands on accept, runs the DATAWIDTH
  // divider iterations, registers the selected result on the last one and
  // holds it until the consumer pops it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= MODSEL_IDLE;
      r_a        <= '0;
      r_c        <= '0;
      r_zero     <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_z        <= '0;
      r_outValid <= 1'b0;
`ifdef MODSEL_DIVZERO_ERR_EN
      r_err      <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a    <= i_a;
        r_c    <= i_c;
        r_zero <= i_zero;
        r_rem  <= '0;
        r_cnt  <= LAST_IDX;
      end

      case (r_state)
        MODSEL_IDLE: begin
          if (w_accept) begin
            r_state <= MODSEL_CALC;
          end
        end

        MODSEL_CALC: begin
          r_rem <= w_remNext;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state    <= MODSEL_DONE;
            r_z        <= w_zSel;
            r_outValid <= 1'b1;
`ifdef MODSEL_DIVZERO_ERR_EN
            r_err      <= w_divZero;
`endif
          end
        end

        MODSEL_DONE: begin
          if (i_out_ready) begin
            r_outValid <= 1'b0;
`ifdef MODSEL_DIVZERO_ERR_EN
            r_err      <= 1'b0;
`endif
            r_state    <= w_accept ? MODSEL_CALC : MODSEL_IDLE;
          end
        end

        default: begin
          r_state <= MODSEL_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = w_inReady;
  assign o_out_valid = r_outValid;
  assign o_z         = r_z;
`ifdef MODSEL_DIVZERO_ERR_EN
  assign o_err       = r_err;
`endif

endmodule

// File: tb/tb_mod_select_seq.sv
// tb_mod_select_seq
//   Directed bench for mod_select_seq at DATAWIDTH=8.  Each job carries a
//   hand-computed z (and divide-by-zero flag); handshake timing, hold,
//   back-to-back throughput and asynchronous reset are exercised directly.
//   Build with MODSEL_DIVZERO_ERR_EN defined to also check the err port.
module tb_mod_select_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] a;
  logic [W-1:0] c;
  logic [W-1:0] zero;
  logic [W-1:0] z;
`ifdef MODSEL_DIVZERO_ERR_EN
  logic         err;
`endif

  int checks     = 0;
  int errors     = 0;
  int cycleCount = 0;

  logic [W-1:0] allOnes;

  mod_select_seq #(
    .DATAWIDTH (W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_a         (a),
    .i_c         (c),
    .i_zero      (zero),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_z         (z)
`ifdef MODSEL_DIVZERO_ERR_EN
    ,
    .o_err       (err)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to measure result spacing.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Guard against a hung handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycleCount);
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // The err port only exists with the divide-by-zero feature built in.
  task automatic checkErr(input string tag, input logic expErr);
`ifdef MODSEL_DIVZERO_ERR_EN
    checkOutput(tag, 64'(err), 64'(expErr));
`else
    $display("[TB] %s expected divide-by-zero flag %0d (no err port)", tag, expErr);
`endif
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a job on the input side; inValid stays high until cleared.
  task automatic applyStimulus(input logic [W-1:0] ja, input logic [W-1:0] jc,
                               input logic [W-1:0] jzero);
    a       = ja;
    c       = jc;
    zero    = jzero;
    inValid = 1'b1;
  endtask

  // Count edges until outValid is seen, bounded; an expired bound fails.
  task automatic waitOutValid(input string tag, output int edges);
    edges = 0;
    while (!outValid && edges < 200) begin
      tick();
      edges++;
    end
    if (!outValid) begin
      checkOutput({tag, "_timeout"}, 64'(outValid), 64'(1));
    end
  endtask

  // Full single job from IDLE: accept, latency, result, pop.
  task automatic runJob(input string tag, input logic [W-1:0] ja,
                        input logic [W-1:0] jc, input logic [W-1:0] jzero,
                        input logic [W-1:0] expZ, input logic expErr);
    int edges;
    checkOutput({tag, "_ready"}, 64'(inReady), 64'(1));
    applyStimulus(ja, jc, jzero);
    tick();
    inValid = 1'b0;
    checkOutput({tag, "_busy"}, 64'(inReady), 64'(0));
    waitOutValid(tag, edges);
    checkOutput({tag, "_latency"}, 64'(edges), 64'(W));
    checkOutput({tag, "_z"}, 64'(z), 64'(expZ));
    checkErr({tag, "_err"}, expErr);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput({tag, "_popvalid"}, 64'(outValid), 64'(0));
    checkErr({tag, "_poperr"}, 1'b0);
  endtask

  initial begin
    int edges;
    int t1;
    allOnes  = '1;
    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    a        = '0;
    c        = '0;
    zero     = '0;

    // Reset state.
    #12;
    checkOutput("rst_valid", 64'(outValid), 64'(0));
    checkOutput("rst_z", 64'(z), 64'(0));
    checkErr("rst_err", 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    checkOutput("rst_ready", 64'(inReady), 64'(1));

    // Basic jobs: 10%3=1 matches zero=1 -> c+1; zero=0 -> a-1.
    runJob("job1", W'(10), W'(3), W'(1), W'(4), 1'b0);
    runJob("job2", W'(10), W'(3), W'(0), W'(9), 1'b0);

    // Back-to-back with outReady tied high: 0-1 wraps to all ones, then
    // 6%255=6 matches zero=6 so c+1 wraps to 0.  The second job's data sits
    // on the port during the first CALC and must be ignored until DONE.
    outReady = 1'b1;
    applyStimulus(W'(0), W'(5), W'(1));
    tick();
    applyStimulus(W'(6), allOnes, W'(6));
    waitOutValid("b2b1", edges);
    checkOutput("b2b1_latency", 64'(edges), 64'(W));
    checkOutput("b2b1_z", 64'(z), 64'(allOnes));
    t1 = cycleCount;
    tick();
    inValid = 1'b0;
    checkOutput("b2b_drop", 64'(outValid), 64'(0));
    checkOutput("b2b_busy", 64'(inReady), 64'(0));
    waitOutValid("b2b2", edges);
    checkOutput("b2b_period", 64'(cycleCount - t1), 64'(W + 1));
    checkOutput("b2b2_z", 64'(z), 64'(0));
    tick();
    outReady = 1'b0;
    checkOutput("b2b_idle", 64'(outValid), 64'(0));

    // Zero divisor: g=a=7 matches zero=7 -> c+1=1, flagged; then c=1.
    runJob("divz", W'(7), W'(0), W'(7), W'(1), 1'b1);
    runJob("div1", W'(7), W'(1), W'(0), W'(2), 1'b0);

    // Output hold with new inputs waiting, then pop and accept together.
    applyStimulus(W'(10), W'(3), W'(1));
    tick();
    applyStimulus(W'(20), W'(6), W'(2));
    waitOutValid("hold", edges);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_z", 64'(z), 64'(4));
      checkOutput("hold_ready", 64'(inReady), 64'(0));
      checkOutput("hold_valid", 64'(outValid), 64'(1));
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    inValid  = 1'b0;
    checkOutput("popacc_valid", 64'(outValid), 64'(0));
    checkOutput("popacc_busy", 64'(inReady), 64'(0));
    waitOutValid("popacc", edges);
    checkOutput("popacc_latency", 64'(edges), 64'(W));
    checkOutput("popacc_z", 64'(z), 64'(7));
    outReady = 1'b1;
    tick();
    outReady = 1'b0;

    // Asynchronous reset while a flagged result is being held.
    applyStimulus(W'(7), W'(0), W'(7));
    tick();
    inValid = 1'b0;
    waitOutValid("rstdone", edges);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstdone_valid", 64'(outValid), 64'(0));
    checkOutput("rstdone_z", 64'(z), 64'(0));
    checkErr("rstdone_err", 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    tick();

    // Give z a non-zero value, then reset midway through CALC.
    runJob("pre", W'(7), W'(1), W'(0), W'(2), 1'b0);
    applyStimulus(W'(200), W'(7), W'(0));
    tick();
    inValid = 1'b0;
    tick();
    tick();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstcalc_valid", 64'(outValid), 64'(0));
    checkOutput("rstcalc_z", 64'(z), 64'(0));
    checkErr("rstcalc_err", 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    checkOutput("rstcalc_ready", 64'(inReady), 64'(1));

    // 200%7=4, not 0 -> a-1=199.
    runJob("after", W'(200), W'(7), W'(0), W'(199), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
